// File: rtl/cluster_state_stepper_if.sv
// Host-side bus of cluster_state_stepper.
// Groups word-serial load (ld_*), word read (rd_*) and run control
// (start/n_steps/halt/busy/done/steps_done).
// master: host side. slave: stepper side.
interface cluster_state_stepper_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned STEP_W = 16
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic              start;
  logic [STEP_W-1:0] n_steps;
  logic              halt;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;

  modport master (
    output ld_valid, ld_addr, ld_data, start, n_steps, halt, rd_addr,
    input  ld_ready, busy, done, steps_done, rd_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, start, n_steps, halt, rd_addr,
    output ld_ready, busy, done, steps_done, rd_data
  );
endinterface

// File: rtl/cluster_state_stepper.sv
// State holder and step sequencer for the flattened CPU state vector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : host load/read/run-control interface (slave side)
//   state_o    : registered IN_W-bit vector driven to every evaluator
//   next_i     : OUT_W evaluator outputs, bit k is next value of state bit k
// Each step waits EVAL_CYCLES cycles with state_o held stable, then writes
// next_i into state[OUT_W-1:0]; upper bits only change through host loads.
module cluster_state_stepper #(
  parameter int unsigned IN_W        = 1894,
  parameter int unsigned OUT_W       = 128,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned EVAL_CYCLES = 2,
  parameter int unsigned STEP_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cluster_state_stepper_if.slave   bus,
  output logic [IN_W-1:0]          state_o,
  input  logic [OUT_W-1:0]         next_i
);

  localparam int unsigned NWORDS = (IN_W + WORD_W - 1) / WORD_W;
  localparam int unsigned PAD_W  = NWORDS * WORD_W;
  localparam int unsigned CNT_W  = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EVAL = 1'b1
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [IN_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  eval_cnt_q, eval_cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] steps_inc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ld_ready_q, ld_ready_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic [PAD_W-1:0]  state_pad;
  logic [PAD_W-1:0]  pad_d;

  // Zero-padded view so the last word reads 0 above IN_W.
  assign state_pad = PAD_W'(state_q);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    fsm_d      = fsm_q;
    eval_cnt_d = eval_cnt_q;
    steps_d    = steps_q;
    target_d   = target_q;
    done_d     = 1'b0;
    rd_data_d  = '0;
    pad_d      = state_pad;
    steps_inc  = STEP_W'(steps_q + 1'b1);

    // Host load: applied in IDLE only; the truncation below drops bits past IN_W,
    // and addresses with no matching word fall through untouched.
    if (fsm_q == IDLE && bus.ld_valid) begin
      for (int unsigned w = 0; w < NWORDS; w++) begin
        if (bus.ld_addr == ADDR_W'(w)) begin
          pad_d[w*WORD_W +: WORD_W] = bus.ld_data;
        end
      end
    end
    state_d = IN_W'(pad_d);

    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          steps_d = '0;
          if (bus.n_steps == '0) begin
            done_d = 1'b1;
          end else begin
            target_d   = bus.n_steps;
            eval_cnt_d = '0;
            fsm_d      = EVAL;
          end
        end
      end
      EVAL: begin
        // Halt wins over a commit landing on the same cycle.
        if (bus.halt) begin
          fsm_d = IDLE;
        end else if (eval_cnt_q == CNT_W'(EVAL_CYCLES - 1)) begin
          state_d[OUT_W-1:0] = next_i;
          steps_d            = steps_inc;
          eval_cnt_d         = '0;
          if (steps_inc == target_q) begin
            done_d = 1'b1;
            fsm_d  = IDLE;
          end
        end else begin
          eval_cnt_d = CNT_W'(eval_cnt_q + 1'b1);
        end
      end
      default: fsm_d = IDLE;
    endcase

    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (bus.rd_addr == ADDR_W'(w)) begin
        rd_data_d = state_pad[w*WORD_W +: WORD_W];
      end
    end

    busy_d     = (fsm_d == EVAL);
    ld_ready_d = (fsm_d == IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      eval_cnt_q <= '0;
      steps_q    <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_ready_q <= 1'b1;
      rd_data_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      eval_cnt_q <= eval_cnt_d;
      steps_q    <= steps_d;
      target_q   <= target_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ld_ready_q <= ld_ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign state_o        = state_q;
  assign bus.ld_ready   = ld_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_done = steps_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_cluster_state_stepper.sv
// Scoreboard bench for cluster_state_stepper: stimulus pushes expected read
// words and expected done/steps_done values; a negedge monitor pops them when
// the DUT presents rd_data (one cycle after a read request) or a done pulse.
module tb_cluster_state_stepper;

  localparam int unsigned IN_W   = 1894;
  localparam int unsigned OUT_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned NWORDS = 60;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  state_o;
  logic [OUT_W-1:0] next_i;
  logic             inv_mode;
  logic             rd_req;
  logic             rd_pend;

  logic [31:0] mdl [NWORDS];
  logic [31:0] rd_q [$];
  logic [15:0] done_q [$];
  int n_vec;
  int n_err;

  cluster_state_stepper_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .STEP_W(STEP_W)) bus ();

  cluster_state_stepper #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
    .EVAL_CYCLES(2), .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_o(state_o),
    .next_i(next_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Evaluator stand-in: all-ones, or inverse of current low state bits.
  always_comb next_i = inv_mode ? ~state_o[OUT_W-1:0] : {OUT_W{1'b1}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_req;
  end

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares whenever the DUT presents read data or a done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_pend) begin
        if (rd_q.size() == 0) check("rd_underflow", 128'(rd_q.size()), 128'(1));
        else check("rd_data", 128'(bus.rd_data), 128'(rd_q.pop_front()));
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("done_unexpected", 128'(bus.done), 128'(0));
        else check("done_steps", 128'(bus.steps_done), 128'(done_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = ADDR_W'(a);
    bus.ld_data  = d;
    if (a < int'(NWORDS)) mdl[a] = (a == int'(NWORDS) - 1) ? (d & 32'h0000_003F) : d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  function automatic logic [127:0] mdl128();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic set128(input logic [127:0] v);
    for (int w = 0; w < 4; w++) mdl[w] = v[w*32 +: 32];
  endtask

  task automatic wr128(input logic [127:0] v);
    for (int w = 0; w < 4; w++) wr(w, v[w*32 +: 32]);
  endtask

  task automatic read_word(input int a, input logic [31:0] exp);
    bus.rd_addr = ADDR_W'(a);
    rd_q.push_back(exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic readback_all();
    for (int a = 0; a < int'(NWORDS); a++) begin
      bus.rd_addr = ADDR_W'(a);
      rd_q.push_back(mdl[a]);
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic start_run(input int n);
    bus.start   = 1'b1;
    bus.n_steps = STEP_W'(n);
    tick();
    bus.start   = 1'b0;
  endtask

  logic [127:0] init_v;
  logic [127:0] exp_v;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; inv_mode = 1'b0; rd_req = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 1'b0; bus.n_steps = '0; bus.halt = 1'b0; bus.rd_addr = '0;
    for (int a = 0; a < int'(NWORDS); a++) mdl[a] = '0;
    repeat (3) tick();

    check("rst_ld_ready", 128'(bus.ld_ready), 128'(1));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_steps", 128'(bus.steps_done), 128'(0));
    rst_n = 1'b1;
    tick();

    // Reset readback, plus an out-of-range address.
    readback_all();
    read_word(63, 32'h0);

    // Loads: last word keeps only 1894-59*32 = 6 bits; addr 63 is ignored.
    wr(2, 32'hDEAD_BEEF);
    wr(59, 32'hFFFF_FFFF);
    wr(63, 32'hA5A5_A5A5);
    check("wr_latency", 128'(state_o[95:64]), 128'(32'hDEAD_BEEF));
    read_word(2, 32'hDEAD_BEEF);
    read_word(59, 32'h0000_003F);
    readback_all();

    // Single step, next_i all ones.
    inv_mode = 1'b0;
    init_v = mdl128();
    done_q.push_back(16'd1);
    start_run(1);
    check("s1_busy", 128'(bus.busy), 128'(1));
    check("s1_ld_ready", 128'(bus.ld_ready), 128'(0));
    tick();
    check("s1_hold", state_o[127:0], init_v);
    tick();
    check("s1_commit", state_o[127:0], {128{1'b1}});
    check("s1_done", 128'(bus.done), 128'(1));
    check("s1_steps", 128'(bus.steps_done), 128'(1));
    set128({128{1'b1}});
    tick();
    check("s1_done_drop", 128'(bus.done), 128'(0));
    readback_all();

    // Five inverting steps: commits on every second edge.
    inv_mode = 1'b1;
    init_v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wr128(init_v);
    done_q.push_back(16'd5);
    start_run(5);
    check("m_busy0", 128'(bus.busy), 128'(1));
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_v = ((c / 2) % 2 == 1) ? ~init_v : init_v;
      check("m_state", state_o[127:0], exp_v);
      check("m_busy", 128'(bus.busy), 128'(c < 10));
      check("m_steps", 128'(bus.steps_done), 128'(c / 2));
    end
    set128(~init_v);
    tick();
    readback_all();

    // Halt on step 4's commit cycle; a write during EVAL is ignored.
    init_v = 128'h0F0F_0000_FFFF_1234_AAAA_5555_0000_C3C3;
    wr128(init_v);
    start_run(10);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 2) begin
        bus.ld_valid = 1'b1; bus.ld_addr = 6'd10; bus.ld_data = 32'hCAFE_F00D;
        check("e_ld_ready", 128'(bus.ld_ready), 128'(0));
      end
      if (c == 3) bus.ld_valid = 1'b0;
    end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("h_busy", 128'(bus.busy), 128'(0));
    check("h_ld_ready", 128'(bus.ld_ready), 128'(1));
    check("h_steps", 128'(bus.steps_done), 128'(3));
    check("h_state", state_o[127:0], ~init_v);
    tick();
    check("h_state_hold", state_o[127:0], ~init_v);
    set128(~init_v);
    readback_all();

    // Zero-step run: done next cycle, steps_done cleared, never busy.
    done_q.push_back(16'd0);
    start_run(0);
    check("z_busy", 128'(bus.busy), 128'(0));
    check("z_done", 128'(bus.done), 128'(1));
    check("z_steps", 128'(bus.steps_done), 128'(0));
    tick();
    check("z_busy2", 128'(bus.busy), 128'(0));

    // Write and start together: the step sees the written word.
    exp_v = mdl128();
    exp_v[63:32] = 32'h1234_5678;
    exp_v = ~exp_v;
    bus.ld_valid = 1'b1; bus.ld_addr = 6'd1; bus.ld_data = 32'h1234_5678;
    done_q.push_back(16'd1);
    start_run(1);
    bus.ld_valid = 1'b0;
    tick();
    tick();
    check("ws_word1", 128'(state_o[63:32]), 128'(32'hEDCB_A987));
    check("ws_state", state_o[127:0], exp_v);
    set128(exp_v);
    tick();
    readback_all();

    // Reset in the middle of a run.
    start_run(10);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("r_busy", 128'(bus.busy), 128'(0));
    check("r_done", 128'(bus.done), 128'(0));
    check("r_ld_ready", 128'(bus.ld_ready), 128'(1));
    check("r_steps", 128'(bus.steps_done), 128'(0));
    check("r_rd_data", 128'(bus.rd_data), 128'(0));
    check("r_state_lo", state_o[127:0], 128'(0));
    check("r_state_hi", 128'(state_o[IN_W-1:IN_W-32]), 128'(0));
    for (int a = 0; a < int'(NWORDS); a++) mdl[a] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    readback_all();

    repeat (3) tick();
    check("rd_q_empty", 128'(rd_q.size()), 128'(0));
    check("done_q_empty", 128'(done_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
